// File: rtl/conc_capture_pkg.sv
// conc_capture_pkg
// Shared constants and entry layout for the concolic response capture block.
// Optional feature macro: CONC_CAPTURE_TS_EN (entries carry a cycle timestamp).
// Entry layout: {ts, data} with data at DATA_LSB and the timestamp directly above it.
package conc_capture_pkg;

  localparam int unsigned DEF_DATA_W = 6;
  localparam int unsigned DEF_CNT_W  = 32;

  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned TS_LSB   = DATA_LSB + DEF_DATA_W;

`ifdef CONC_CAPTURE_TS_EN
  typedef struct packed {
    logic [DEF_CNT_W-1:0]  ts;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;
`else
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
  } entry_t;
`endif

  // Width of one buffer entry for the given data/counter widths.
  function automatic int unsigned entry_w(input int unsigned data_w, input int unsigned cnt_w);
`ifdef CONC_CAPTURE_TS_EN
    return data_w + cnt_w;
`else
    if (cnt_w == 0) return data_w;
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/conc_capture_fifo.sv
// conc_capture_fifo
// First-word fall-through circular buffer with an explicit occupancy counter.
// A push into a full buffer is accepted only when a pop happens on the same edge.
// Ports:
//   clock, reset_n   rising-edge clock, async active-low reset
//   i_clr            synchronous clear of pointers and level (priority over push/pop)
//   i_push, i_wdata  write request and data
//   i_pop            read request (ignored while empty)
//   o_valid, o_rdata buffer non-empty, oldest entry (zero while empty)
//   o_level          number of stored entries
//   o_accept         the push on this edge is accepted
module conc_capture_fifo #(
  parameter int unsigned W     = 6,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       i_clr,
  input  logic                       i_push,
  input  logic [W-1:0]               i_wdata,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [W-1:0]               o_rdata,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_accept
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_pop;
  logic w_full;
  logic w_push;

  always_comb begin
    o_valid  = (r_level != '0);
    w_pop    = o_valid & i_pop;
    w_full   = (r_level == LW'(DEPTH));
    w_push   = i_push & (~w_full | w_pop);
    o_accept = w_push;
    o_level  = r_level;
    o_rdata  = o_valid ? r_mem[r_rd_ptr] : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage has no reset; contents are only observed through o_rdata while valid.
  always_ff @(posedge clock) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/conc_resp_capture.sv
// conc_resp_capture
// Samples a DUT output vector on enabled clock edges into a circular trace buffer,
// optionally storing only changes, and drains it through a valid/ready port.
// Optional feature macro: CONC_CAPTURE_TS_EN (adds rd_ts, entries hold {cyc, dut_out}).
// Ports:
//   clock, reset_n    rising-edge clock, async active-low reset
//   cap_en            sample on this edge
//   clr               synchronous clear of buffer, counters and flags
//   dut_out           sampled vector
//   rd_valid/rd_ready read handshake; rd_data (and rd_ts) hold the oldest entry
//   level             stored entries
//   overflow          sticky: a sample was dropped
//   cyc               enabled-cycle counter
module conc_resp_capture
  import conc_capture_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter bit          CHANGE_ONLY = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cap_en,
  input  logic                    clr,
  input  logic [DATA_W-1:0]       dut_out,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_W-1:0]       rd_data,
`ifdef CONC_CAPTURE_TS_EN
  output logic [CNT_W-1:0]        rd_ts,
`endif
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CNT_W-1:0]        cyc
);

  localparam int unsigned ENTRY_W = entry_w(DATA_W, CNT_W);

  logic [CNT_W-1:0]   r_cyc;
  logic [DATA_W-1:0]  r_last;
  logic               r_last_vld;
  logic               r_ovf;

  logic               w_store;
  logic               w_accept;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;

  always_comb begin
    w_store = cap_en & (~CHANGE_ONLY | ~r_last_vld | (dut_out != r_last));
`ifdef CONC_CAPTURE_TS_EN
    w_wdata = {r_cyc, dut_out};
    rd_ts   = w_rdata[DATA_LSB + DATA_W +: CNT_W];
`else
    w_wdata = dut_out;
`endif
    rd_data  = w_rdata[DATA_LSB +: DATA_W];
    overflow = r_ovf;
    cyc      = r_cyc;
  end

  conc_capture_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_clr    (clr),
    .i_push   (w_store & ~clr),
    .i_wdata  (w_wdata),
    .i_pop    (rd_ready),
    .o_valid  (rd_valid),
    .o_rdata  (w_rdata),
    .o_level  (level),
    .o_accept (w_accept)
  );

  // A dropped sample still becomes the reference value, so a single change
  // raises overflow at most once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc      <= '0;
      r_last     <= '0;
      r_last_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (clr) begin
      r_cyc      <= '0;
      r_last_vld <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (cap_en) r_cyc <= r_cyc + CNT_W'(1);
      if (w_store) begin
        r_last     <= dut_out;
        r_last_vld <= 1'b1;
        if (!w_accept) r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conc_resp_capture.sv
// Bench for conc_resp_capture: instance A has CHANGE_ONLY=1, instance B has
// CHANGE_ONLY=0; both share clock, reset, cap_en, clr and dut_out.
module tb_conc_resp_capture;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        cap_en  = 1'b0;
  logic        clr     = 1'b0;
  logic        rdy_a   = 1'b0;
  logic        rdy_b   = 1'b0;
  logic [5:0]  dut_out = '0;

  logic        a_valid, b_valid, a_ovf, b_ovf;
  logic [5:0]  a_data, b_data;
  logic [4:0]  a_level, b_level;
  logic [31:0] a_cyc, b_cyc;
`ifdef CONC_CAPTURE_TS_EN
  logic [31:0] a_ts, b_ts;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0]  d;
    logic [31:0] ts;
  } ent_t;

  ent_t        mq [2][$];
  bit          m_ovf [2];
  bit          m_lv [2];
  logic [5:0]  m_last [2];
  logic [31:0] m_cyc;

  always #5 clock = ~clock;

  conc_resp_capture #(.DATA_W(6), .DEPTH(16), .CNT_W(32), .CHANGE_ONLY(1'b1)) u_a (
    .clock(clock), .reset_n(reset_n), .cap_en(cap_en), .clr(clr), .dut_out(dut_out),
    .rd_valid(a_valid), .rd_ready(rdy_a), .rd_data(a_data),
`ifdef CONC_CAPTURE_TS_EN
    .rd_ts(a_ts),
`endif
    .level(a_level), .overflow(a_ovf), .cyc(a_cyc)
  );

  conc_resp_capture #(.DATA_W(6), .DEPTH(16), .CNT_W(32), .CHANGE_ONLY(1'b0)) u_b (
    .clock(clock), .reset_n(reset_n), .cap_en(cap_en), .clr(clr), .dut_out(dut_out),
    .rd_valid(b_valid), .rd_ready(rdy_b), .rd_data(b_data),
`ifdef CONC_CAPTURE_TS_EN
    .rd_ts(b_ts),
`endif
    .level(b_level), .overflow(b_ovf), .cyc(b_cyc)
  );

  // Reference model: a queue per instance, updated from the inputs present
  // just before the clock edge.
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_ovf[i]  = 1'b0;
      m_lv[i]   = 1'b0;
      m_last[i] = '0;
    end
    m_cyc = '0;
  endtask

  task automatic model_step();
    bit co, rdy, st;
    for (int i = 0; i < 2; i++) begin
      co  = (i == 0);
      rdy = (i == 0) ? rdy_a : rdy_b;
      if (clr) begin
        mq[i].delete();
        m_ovf[i] = 1'b0;
        m_lv[i]  = 1'b0;
      end else begin
        st = cap_en && (!co || !m_lv[i] || dut_out != m_last[i]);
        if (rdy && mq[i].size() > 0) void'(mq[i].pop_front());
        if (st) begin
          m_last[i] = dut_out;
          m_lv[i]   = 1'b1;
          if (mq[i].size() < 16) mq[i].push_back('{d: dut_out, ts: m_cyc});
          else m_ovf[i] = 1'b1;
        end
      end
    end
    if (clr) m_cyc = '0;
    else if (cap_en) m_cyc = m_cyc + 32'd1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    cap_en  = 1'b0;
    clr     = 1'b0;
    rdy_a   = 1'b0;
    rdy_b   = 1'b0;
    dut_out = '0;
    reset_n = 1'b0;
    #3;
    model_reset();
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got a=%b b=%b exp 0", a_valid, b_valid); end
    total++; if (a_level !== 5'd0 || b_level !== 5'd0) begin bad++; $display("FAIL reset_level got a=%0d b=%0d exp 0", a_level, b_level); end
    total++; if (a_ovf !== 1'b0 || b_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got a=%b b=%b exp 0", a_ovf, b_ovf); end
    total++; if (a_cyc !== 32'd0 || b_cyc !== 32'd0) begin bad++; $display("FAIL reset_cyc got a=%0d b=%0d exp 0", a_cyc, b_cyc); end
    total++; if (a_data !== 6'd0 || b_data !== 6'd0) begin bad++; $display("FAIL reset_data got a=%0h b=%0h exp 0", a_data, b_data); end
  endtask

  task automatic test_hold();
    do_reset();
    dut_out = 6'h05;
    cap_en  = 1'b1;
    repeat (4) tick();
    cap_en = 1'b0;
    total++; if (a_level !== 5'd1) begin bad++; $display("FAIL hold_level got %0d exp 1", a_level); end
    total++; if (a_data !== 6'h05) begin bad++; $display("FAIL hold_data got %0h exp 05", a_data); end
    total++; if (a_cyc !== 32'd4) begin bad++; $display("FAIL hold_cyc got %0d exp 4", a_cyc); end
`ifdef CONC_CAPTURE_TS_EN
    total++; if (a_ts !== 32'd0) begin bad++; $display("FAIL hold_ts got %0d exp 0", a_ts); end
`endif
  endtask

  task automatic test_overflow();
    logic [5:0] s [18];
    do_reset();
    cap_en = 1'b1;
    for (int k = 0; k < 18; k++) begin
      s[k]    = 6'($urandom);
      dut_out = s[k];
      tick();
    end
    cap_en = 1'b0;
    total++; if (b_level !== 5'd16) begin bad++; $display("FAIL ovf_level got %0d exp 16", b_level); end
    total++; if (b_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got %b exp 1", b_ovf); end
    rdy_b = 1'b1;
    for (int k = 0; k < 16; k++) begin
      total++;
      if (b_valid !== 1'b1 || b_data !== s[k]) begin
        bad++; $display("FAIL ovf_drain[%0d] got v=%b d=%0h exp v=1 d=%0h", k, b_valid, b_data, s[k]);
      end
`ifdef CONC_CAPTURE_TS_EN
      total++; if (b_ts !== 32'(k)) begin bad++; $display("FAIL ovf_ts[%0d] got %0d exp %0d", k, b_ts, k); end
`endif
      tick();
    end
    rdy_b = 1'b0;
    total++; if (b_valid !== 1'b0 || b_level !== 5'd0) begin bad++; $display("FAIL ovf_empty got v=%b l=%0d exp 0/0", b_valid, b_level); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] s [17];
    do_reset();
    cap_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      s[k]    = 6'($urandom);
      dut_out = s[k];
      tick();
    end
    s[16]   = 6'($urandom);
    dut_out = s[16];
    rdy_b   = 1'b1;
    tick();
    cap_en = 1'b0;
    total++; if (b_level !== 5'd16) begin bad++; $display("FAIL b2b_level got %0d exp 16", b_level); end
    total++; if (b_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf got %b exp 0", b_ovf); end
    for (int k = 1; k < 17; k++) begin
      total++;
      if (b_valid !== 1'b1 || b_data !== s[k]) begin
        bad++; $display("FAIL b2b_drain[%0d] got v=%b d=%0h exp v=1 d=%0h", k, b_valid, b_data, s[k]);
      end
`ifdef CONC_CAPTURE_TS_EN
      total++; if (b_ts !== 32'(k)) begin bad++; $display("FAIL b2b_ts[%0d] got %0d exp %0d", k, b_ts, k); end
`endif
      tick();
    end
    rdy_b = 1'b0;
  endtask

  task automatic test_change_only();
    logic [5:0] seq [5];
    logic [5:0] exp_d [3];
    logic [31:0] exp_t [3];
    seq   = '{6'd1, 6'd1, 6'd2, 6'd2, 6'd1};
    exp_d = '{6'd1, 6'd2, 6'd1};
    exp_t = '{32'd0, 32'd2, 32'd4};
    do_reset();
    cap_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      dut_out = seq[k];
      tick();
    end
    cap_en = 1'b0;
    total++; if (a_level !== 5'd3) begin bad++; $display("FAIL chg_level got %0d exp 3", a_level); end
    rdy_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (a_valid !== 1'b1 || a_data !== exp_d[k]) begin
        bad++; $display("FAIL chg_drain[%0d] got v=%b d=%0h exp v=1 d=%0h", k, a_valid, a_data, exp_d[k]);
      end
`ifdef CONC_CAPTURE_TS_EN
      total++; if (a_ts !== exp_t[k]) begin bad++; $display("FAIL chg_ts[%0d] got %0d exp %0d", k, a_ts, exp_t[k]); end
`else
      if (exp_t[k] > 32'd4) $display("unexpected timestamp table entry %0d", k);
`endif
      tick();
    end
    rdy_a = 1'b0;
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL chg_empty got %b exp 0", a_valid); end
  endtask

  task automatic test_clr();
    do_reset();
    dut_out = 6'h07;
    cap_en  = 1'b1;
    repeat (40) tick();
    cap_en = 1'b0;
    rdy_b  = 1'b1;
    repeat (11) tick();
    total++; if (b_level !== 5'd5 || b_ovf !== 1'b1 || b_cyc !== 32'd40) begin
      bad++; $display("FAIL clr_setup got l=%0d o=%b c=%0d exp 5/1/40", b_level, b_ovf, b_cyc);
    end
    total++; if (a_level !== 5'd1) begin bad++; $display("FAIL clr_setup_a got %0d exp 1", a_level); end
    clr    = 1'b1;
    cap_en = 1'b1;
    tick();
    clr    = 1'b0;
    cap_en = 1'b0;
    rdy_b  = 1'b0;
    total++; if (b_level !== 5'd0 || b_valid !== 1'b0) begin bad++; $display("FAIL clr_level got l=%0d v=%b exp 0/0", b_level, b_valid); end
    total++; if (b_ovf !== 1'b0 || b_cyc !== 32'd0) begin bad++; $display("FAIL clr_flags got o=%b c=%0d exp 0/0", b_ovf, b_cyc); end
    total++; if (a_level !== 5'd0 || a_cyc !== 32'd0) begin bad++; $display("FAIL clr_a got l=%0d c=%0d exp 0/0", a_level, a_cyc); end
    cap_en = 1'b1;
    tick();
    cap_en = 1'b0;
    total++; if (a_level !== 5'd1 || a_data !== 6'h07) begin bad++; $display("FAIL clr_restore got l=%0d d=%0h exp 1/07", a_level, a_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cap_en = 1'b1;
    repeat (3) tick();
    cap_en = 1'b0;
    total++; if (b_level !== 5'd3) begin bad++; $display("FAIL areset_setup got %0d exp 3", b_level); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (b_valid !== 1'b0 || b_level !== 5'd0) begin bad++; $display("FAIL areset_now got v=%b l=%0d exp 0/0", b_valid, b_level); end
    total++; if (b_cyc !== 32'd0 || a_level !== 5'd0) begin bad++; $display("FAIL areset_cyc got c=%0d al=%0d exp 0/0", b_cyc, a_level); end
    model_reset();
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    logic        gv, go;
    logic [4:0]  gl;
    logic [5:0]  gd;
    logic [31:0] gc;
    int          n;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      cap_en  = ($urandom_range(0, 9) < 7);
      dut_out = 6'($urandom_range(0, 3));
      rdy_a   = ($urandom_range(0, 9) < 3);
      rdy_b   = ($urandom_range(0, 9) < 4);
      clr     = ($urandom_range(0, 99) < 2);
      tick();
      for (int i = 0; i < 2; i++) begin
        gv = (i == 0) ? a_valid : b_valid;
        gl = (i == 0) ? a_level : b_level;
        gd = (i == 0) ? a_data  : b_data;
        go = (i == 0) ? a_ovf   : b_ovf;
        gc = (i == 0) ? a_cyc   : b_cyc;
        n  = mq[i].size();
        total++; if (gl !== 5'(n) || gv !== (n != 0)) begin
          bad++; $display("FAIL rnd_level[%0d] cycle %0d got l=%0d v=%b exp l=%0d", i, c, gl, gv, n);
        end
        total++; if (go !== m_ovf[i] || gc !== m_cyc) begin
          bad++; $display("FAIL rnd_flags[%0d] cycle %0d got o=%b c=%0d exp o=%b c=%0d", i, c, go, gc, m_ovf[i], m_cyc);
        end
        if (n != 0) begin
          total++; if (gd !== mq[i][0].d) begin
            bad++; $display("FAIL rnd_data[%0d] cycle %0d got %0h exp %0h", i, c, gd, mq[i][0].d);
          end
`ifdef CONC_CAPTURE_TS_EN
          total++; if (((i == 0) ? a_ts : b_ts) !== mq[i][0].ts) begin
            bad++; $display("FAIL rnd_ts[%0d] cycle %0d got %0d exp %0d", i, c, ((i == 0) ? a_ts : b_ts), mq[i][0].ts);
          end
`endif
        end
      end
    end
    clr    = 1'b0;
    cap_en = 1'b0;
    rdy_a  = 1'b0;
    rdy_b  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold();
    test_overflow();
    test_back_to_back();
    test_change_only();
    test_clr();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conc_resp_capture.md
Name: conc_resp_capture

Overview:
- Response-side counterpart of the concolic stimulus player: samples the DUT output vector every clock and stores samples in a circular trace buffer.
- Buffered samples are drained through a valid/ready read port for the harness.
- Sits beside the DUT instance, e.g. on b06 outputs {cc_mux, uscite, enable_count, ackout} = 6 bits.

Parameters:
DATA_W, 6, width of the sampled DUT output vector
DEPTH, 16, buffer entries; power of 2, >= 2
CNT_W, 32, width of the cycle counter
CHANGE_ONLY, 1, 1 = store only samples that differ from the last stored one; 0 = store every enabled cycle

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cap_en  in  1  capture enable; sample taken on clock edges where high
clr  in  1  synchronous clear of buffer, counters and flags; priority over everything except reset_n
dut_out  in  DATA_W  DUT output vector to sample
rd_valid  out  1  buffer non-empty; rd_data holds the oldest entry
rd_ready  in  1  harness pops the entry on a clock edge where rd_valid & rd_ready
rd_data  out  DATA_W  oldest stored sample
rd_ts  out  CNT_W  cycle index of rd_data (only with CONC_CAPTURE_TS_EN)
level  out  $clog2(DEPTH)+1  number of stored entries
overflow  out  1  sticky: at least one sample was dropped
cyc  out  CNT_W  enabled-cycle counter

Behaviour:
- Reset: rd_valid=0, level=0, overflow=0, cyc=0, rd_data=0, rd_ts=0, write/read pointers=0, last-sample-valid=0.
- cyc: increments by 1 on each edge with cap_en=1; wraps modulo 2^CNT_W. The sample taken on an edge is tagged with the pre-increment cyc.
- Store decision on an edge with cap_en=1:
  - CHANGE_ONLY=0: always store.
  - CHANGE_ONLY=1: store if last-sample-valid=0 or dut_out != last stored value. After a store, last stored value = dut_out and last-sample-valid=1.
  - A dropped sample still updates the last stored value, so one change produces at most one overflow event.
- Write acceptance: accepted if level < DEPTH, or level == DEPTH with a pop on the same edge. Otherwise the sample is dropped and overflow is set (sticky until clr/reset).
- Read: rd_data/rd_ts come combinationally from the entry at rd_ptr. Pop when rd_valid & rd_ready; rd_ready with rd_valid=0 is ignored.
- Latency: a sample stored on edge N is visible with rd_valid=1 after edge N (first-word fall-through, 1 cycle).
- Simultaneous push and pop: level unchanged, both pointers advance.
- Pointers: wrap modulo DEPTH. level is kept as an explicit counter, so full and empty are unambiguous.
- clr=1: on that edge, pointers, level, overflow, cyc and last-sample-valid are set to 0. Any sample and pop on that edge are discarded.
- Reset mid-operation: state returns immediately to reset values; buffer RAM contents are don't-care.
- cap_en=0: no sample, cyc holds; reads continue.

Optional Feature:
- Macro: CONC_CAPTURE_TS_EN.
- Defined: each entry stores {cyc, dut_out} and the rd_ts port exists. The buffer is DATA_W+CNT_W wide.
- Undefined: rd_ts port is absent, entries are DATA_W wide, and cyc is still counted and output.

Decomposition:
- Package conc_capture_pkg: default DATA_W/CNT_W constants, entry-field offset localparams (TS_LSB, DATA_LSB), and the entry struct typedef guarded by the macro.
- Sub-module conc_capture_fifo: parameterised by width and depth. Holds pointers, level, storage, push/pop arbitration and the full-with-pop rule.
- Top block keeps cyc, change detection, overflow and clr fan-out.

Test Plan:
- Reset, CHANGE_ONLY=1, cap_en=1, dut_out=6'h05 held for 4 cycles, rd_ready=0 -> level=1, rd_data=6'h05, rd_ts=0, cyc=4.
- CHANGE_ONLY=0, DEPTH=16, cap_en=1 for 18 cycles, rd_ready=0 -> level=16, overflow=1, rd_data holds the cycle-0 sample. Then rd_ready=1 for 16 cycles pops samples 0..15 in order.
- Full buffer (level=16) with push and pop on the same edge -> level stays 16, overflow stays 0, new sample stored at tail.
- dut_out sequence 1,1,2,2,1 with CHANGE_ONLY=1 -> exactly 3 entries: 1 (ts 0), 2 (ts 2), 1 (ts 4).
- clr asserted with level=5, overflow=1, cyc=40, and a sample on the same edge -> next cycle level=0, rd_valid=0, overflow=0, cyc=0. Next sample is stored even if equal to the pre-clr value.
- reset_n pulsed low mid-readout (level=3), asynchronous to clock -> rd_valid=0 and level=0 immediately, before the next clock edge.
